// File: rtl/aes_dec_21cc.sv
// AES-128 inverse cipher, fixed 21-edge schedule.
// Forward key expansion, then one inverse round per clock.
module aes_dec_21cc (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] g_init,
  input  logic [127:0] e_init,
  output logic [127:0] o,
  output logic         done
);

  typedef enum logic [1:0] {KEXP, DEC, FIN, IDLE} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] st_q, st_d;
  logic [127:0] o_q, o_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, w3x;
  logic [31:0]  sw_in, sw_rot, sw_out, rc_w;
  logic [3:0]   rc_idx;
  logic [127:0] key_fwd, key_inv;
  logic [127:0] isr, isb, ark, imc;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < 6; i++) y = gmul(gmul(y, y), x);
    return gmul(y, y);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] n);
    return (x << n) | (x >> (4'd8 - {1'b0, n}));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = ginv(b);
    return x ^ rotl(x, 3'd1) ^ rotl(x, 3'd2) ^ rotl(x, 3'd3) ^ rotl(x, 3'd4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rotl(s, 3'd1) ^ rotl(s, 3'd3) ^ rotl(s, 3'd6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign o    = o_q;
  assign done = done_q;

  // shared SubWord: forward step uses w3, inverse step uses w3^w2
  always_comb begin
    w0      = key_q[31:0];
    w1      = key_q[63:32];
    w2      = key_q[95:64];
    w3      = key_q[127:96];
    w3x     = w3 ^ w2;
    sw_in   = (state_q == KEXP) ? w3 : w3x;
    sw_rot  = {sw_in[7:0], sw_in[31:8]};
    sw_out  = {sbox(sw_rot[31:24]), sbox(sw_rot[23:16]),
               sbox(sw_rot[15:8]), sbox(sw_rot[7:0])};
    rc_idx  = (state_q == KEXP) ? cnt_q + 4'd1 : cnt_q;
    rc_w    = {24'h0, rcon(rc_idx)};
    key_fwd[31:0]   = w0 ^ sw_out ^ rc_w;
    key_fwd[63:32]  = w1 ^ key_fwd[31:0];
    key_fwd[95:64]  = w2 ^ key_fwd[63:32];
    key_fwd[127:96] = w3 ^ key_fwd[95:64];
    key_inv = {w3x, w2 ^ w1, w1 ^ w0, w0 ^ sw_out ^ rc_w};
  end

  // inverse round datapath on the state register
  always_comb begin
    isr = '0;
    isb = '0;
    imc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[8*(r+4*c) +: 8] = st_q[8*(r+4*((c+4-r)%4)) +: 8];
    for (int i = 0; i < 16; i++)
      isb[8*i +: 8] = isbox(isr[8*i +: 8]);
    ark = isb ^ key_q;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        imc[8*(r+4*c) +: 8] =
          gmul(8'h0e, ark[8*(r+4*c) +: 8]) ^
          gmul(8'h0b, ark[8*((r+1)%4+4*c) +: 8]) ^
          gmul(8'h0d, ark[8*((r+2)%4+4*c) +: 8]) ^
          gmul(8'h09, ark[8*((r+3)%4+4*c) +: 8]);
  end

  // next-state: key expansion, inverse rounds, final output
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    done_d  = done_q;
    unique case (state_q)
      KEXP: begin
        key_d = key_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = DEC;
      end
      DEC: begin
        key_d = key_inv;
        cnt_d = cnt_q - 4'd1;
        st_d  = (cnt_q == 4'd10) ? (st_q ^ key_q) : imc;
        if (cnt_q == 4'd1) state_d = FIN;
      end
      FIN: begin
        o_d     = ark;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      IDLE: ;
    endcase
  end

  // state registers; reset also loads the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KEXP;
      key_q   <= g_init;
      st_q    <= e_init;
      cnt_q   <= 4'd0;
      o_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_21cc.sv
// Bench for aes_dec_21cc: vector table, corner sequences,
// random round-trips against a byte-level AES model.
module tb_aes_dec_21cc;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] g_init, e_init, o;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [7:0]   tsb [256];
  logic [7:0]   tisb [256];
  logic [127:0] rk [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t tbl [4];

  aes_dec_21cc dut (
    .clk(clk), .rst(rst), .g_init(g_init),
    .e_init(e_init), .o(o), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ce(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {tsb[w[31:24]], tsb[w[23:16]], tsb[w[15:8]], tsb[w[7:0]]};
  endfunction

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s, t;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[8*i +: 8] = tsb[s[8*i +: 8]];
      s = t;
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[8*(row+4*col) +: 8] = s[8*(row+4*((col+row)%4)) +: 8];
      s = t;
      if (r < 10) begin
        for (int col = 0; col < 4; col++)
          for (int row = 0; row < 4; row++)
            t[8*(row+4*col) +: 8] =
              mul(8'h02, s[8*(row+4*col) +: 8]) ^
              mul(8'h03, s[8*((row+1)%4+4*col) +: 8]) ^
              s[8*((row+2)%4+4*col) +: 8] ^
              s[8*((row+3)%4+4*col) +: 8];
        s = t;
      end
      s = s ^ rk[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct);
    logic [127:0] s, t;
    s = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[8*(row+4*((col+row)%4)) +: 8] = s[8*(row+4*col) +: 8];
      s = t;
      for (int i = 0; i < 16; i++) t[8*i +: 8] = tisb[s[8*i +: 8]];
      s = t ^ rk[r];
      if (r > 0) begin
        for (int col = 0; col < 4; col++)
          for (int row = 0; row < 4; row++)
            t[8*(row+4*col) +: 8] =
              mul(8'h0e, s[8*(row+4*col) +: 8]) ^
              mul(8'h0b, s[8*((row+1)%4+4*col) +: 8]) ^
              mul(8'h0d, s[8*((row+2)%4+4*col) +: 8]) ^
              mul(8'h09, s[8*((row+3)%4+4*col) +: 8]);
        s = t;
      end
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one reset edge loading the operands; leaves rst low afterwards
  task automatic apply_reset(input logic [127:0] k, input logic [127:0] c);
    rst = 1'b1;
    g_init = k;
    e_init = c;
    @(posedge clk); #1;
    chk("rst_o", o, '0);
    chk("rst_done", {127'b0, done}, 128'd0);
    rst = 1'b0;
  endtask

  task automatic run_edges(input int n, input logic [127:0] exp,
                           input logic [127:0] k0, input bit probe);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      if (e < 21) begin
        chk("early_o", o, '0);
        chk("early_done", {127'b0, done}, 128'd0);
      end else begin
        chk("final_o", o, exp);
        chk("final_done", {127'b0, done}, 128'd1);
      end
      if (probe && e == 10)
        chk("key_k10", dut.key_q, ce(128'h13111d7fe3944a17f307a78b4d2b30c5));
      if (probe && e == 20)
        chk("key_k0", dut.key_q, k0);
    end
  endtask

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] k, c, pt, v1k, v1c, v1p, v2k, v2c, v2p;

    rst = 1'b1;
    g_init = '0;
    e_init = '0;

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^
          {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      tsb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    tsb[0] = 8'h63;
    for (int i = 0; i < 256; i++) tisb[tsb[i]] = i[7:0];

    v1k = ce(128'h000102030405060708090a0b0c0d0e0f);
    v1c = ce(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    v1p = ce(128'h00112233445566778899aabbccddeeff);
    v2k = 128'he4dc18adf3d05ec9e4dcc41acb990007;
    v2c = 128'hd225406f484809186cb5d86be4098445;
    expand(v2k);
    v2p = dec(v2c);

    tbl[0] = '{v1k, v1c, v1p};
    tbl[1] = '{v2k, v2c, v2p};
    for (int i = 2; i < 4; i++) begin
      k = rnd128();
      pt = rnd128();
      expand(k);
      tbl[i] = '{k, enc(pt), pt};
    end

    @(posedge clk); #1;

    foreach (tbl[i]) begin
      apply_reset(tbl[i].key, tbl[i].ct);
      run_edges(21, tbl[i].pt, tbl[i].key, 1'b0);
    end

    apply_reset(v1k, v1c);
    run_edges(21, v1p, v1k, 1'b1);

    for (int e = 0; e < 50; e++) begin
      g_init = rnd128();
      e_init = rnd128();
      @(posedge clk); #1;
      chk("hold_o", o, v1p);
      chk("hold_done", {127'b0, done}, 128'd1);
    end

    apply_reset(v2k, v2c);
    run_edges(12, '0, v2k, 1'b0);
    apply_reset(v1k, v1c);
    run_edges(21, v1p, v1k, 1'b0);

    for (int i = 0; i < 3; i++) apply_reset(rnd128(), rnd128());
    apply_reset(v2k, v2c);
    run_edges(21, v2p, v2k, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      k = rnd128();
      pt = rnd128();
      expand(k);
      c = enc(pt);
      apply_reset(k, c);
      run_edges(21, pt, k, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_21cc.md
Name: aes_dec_21cc

Overview:
Sequential AES-128 inverse cipher (FIPS-197 decryption), the receive-side counterpart of the team's 11-cycle AES-128 encryptor. Takes the same cipher key as the encryptor plus a ciphertext block and produces the plaintext. It first runs the forward key schedule to reach round key 10, then performs one inverse round per clock, regenerating round keys backwards on the fly. One shared SubWord path and one 16-byte InvSubBytes datapath; no key RAM. Targets garbled-circuit synthesis, so the sequence is fixed-length and data-independent.

Parameters:
none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
clk    input   1    system clock; all state on posedge
rst    input   1    synchronous, active-high reset; also the load strobe for g_init/e_init
g_init input   128  cipher key (same key as given to the encryptor)
e_init input   128  ciphertext block
o      output  128  plaintext; registered
done   output  1    high once o holds the final plaintext; registered

Behaviour:
- Byte order: FIPS-197 byte i sits at bits [8i+7:8i] on g_init, e_init and o. This matches the encryptor and the changeEndian helper in the common header.
- Reset (posedge with rst=1), dominant over everything:
  - key_reg<=g_init, st_reg<=e_init, cnt<=0, fsm<=KEXP, o<=0, done<=0.
  - Inputs are sampled only on reset edges; changes at other times are ignored.
- FSM states: KEXP -> DEC -> FIN -> IDLE. Edges below are counted after rst drops; edge n = nth posedge with rst=0.
- KEXP, edges 1..10:
  - key_reg <= forward expansion of key_reg with Rcon[cnt+1] (01,02,04,08,10,20,40,80,1b,36).
  - cnt increments. After edge 10, key_reg=K10 and cnt=10.
- Edge 11, DEC entry:
  - st_reg <= st_reg ^ K10.
  - key_reg <= K9 via the inverse step from K_r to K_{r-1}, using Rcon[r]:
    - w3'=w3^w2
    - w2'=w2^w1
    - w1'=w1^w0
    - w0'=w0^SubWord(RotWord(w3'))^Rcon[r]
- Edges 12..20, DEC rounds r=9..1:
  - st_reg <= InvMixColumns(InvSubBytes(InvShiftRows(st_reg)) ^ K_r).
  - key_reg <= K_{r-1}; cnt decrements.
- Edge 21, FIN:
  - o <= InvSubBytes(InvShiftRows(st_reg)) ^ K0; done<=1; fsm<=IDLE.
- IDLE:
  - o and done hold indefinitely; no register changes until the next rst.
- Latency: exactly 21 clock edges from the first rst=0 edge to valid o. Data-independent.
- Before done: o=0 and done=0 on every cycle.
- Reset mid-operation (any edge in KEXP/DEC/FIN): abort. o=0, done=0, the new g_init/e_init are loaded, and the sequence restarts from edge 1.
- rst held high for several edges: reloads each edge and stays at cnt=0 with no progress.
- GF(2^8) arithmetic uses polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09. S-box and inverse S-box are constant combinational lookups, FIPS-197 exact.

Test Plan:
1. FIPS-197 C.1: apply changeEndian to the FIPS hex for all three operands.
   - Key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, rst 1 edge then low.
   - After 21 edges: o=00112233445566778899aabbccddeeff, done=1.
   - Edges 1..20: done=0 and o=0.
2. Encryptor round-trip, same byte order:
   - Key e4dc18adf3d05ec9e4dcc41acb990007, ciphertext d225406f484809186cb5d86be4098445.
   - After 21 edges: o=4072da1240f930f7d3c8cf8b9322042e.
3. Internal key-schedule check on vector 1 (hierarchical probe):
   - After edge 10: key_reg=13111d7fe3944a17f307a78b4d2b30c5.
   - After edge 20: key_reg=K0=000102...0f.
4. Hold: after done, run 50 more edges while toggling g_init/e_init randomly -> o and done unchanged.
5. Mid-run reset:
   - Start vector 2, assert rst at edge 13 while presenting vector 1 operands.
   - 21 edges later: o = vector 1 plaintext. o=0 and done=0 in between.
6. Random regression: 1000 random key/plaintext pairs, encrypted with the encryptor (or a C model) and fed here -> o equals the original plaintext every time, at exactly edge 21.
